parity_gen: RTL and testbench
=============================

Name: parity_gen

Overview:
- Registered parity-bit generator for the UART transmitter path.
- Samples a data word and a parity-mode select, then produces the parity bit the TX framer appends after the data bits.
- Also outputs a flag saying whether a parity bit is to be sent at all.
- Sits between the TX holding register and the TX shift/frame FSM.

Parameters:
- DATA_WIDTH, 8, number of data bits covered by parity (legal range 5..9).

Ports:
- clk          input   1           system clock, rising edge
- rst          input   1           asynchronous, active-high reset
- data_in      input   DATA_WIDTH  word to protect
- parity_type  input   2           00 none, 01 odd, 10 even, 11 none (see Optional Feature)
- data_valid   input   1           sample data_in/parity_type this cycle
- parity_out   output  1           computed parity bit (registered)
- parity_en    output  1           1 = framer must insert parity_out; 0 = no parity bit
- out_valid    output  1           one-cycle pulse: parity_out/parity_en updated

Behaviour:
- Reset: while rst=1, parity_out=0, parity_en=0, out_valid=0, independent of clk. Outputs hold these values until the first sampled data_valid after rst deasserts.
- Ones count: ones = XOR-reduction of all DATA_WIDTH bits of data_in (1 = odd number of ones).
- Even (10): parity_out = ones. Total ones including parity is even. parity_en=1.
- Odd (01): parity_out = ~ones. Total ones including parity is odd. parity_en=1.
- None (00, and 11 without the macro): parity_out=0, parity_en=0.
- Latency: on a rising clk edge with data_valid=1, parity_out and parity_en are registered from that cycle's data_in/parity_type. out_valid=1 for exactly that following cycle. Latency is 1 cycle.
- Hold: with data_valid=0, parity_out and parity_en keep their previous values and out_valid=0.
- Back-to-back: data_valid may be high every cycle. Each cycle's result appears on the next cycle, with no bubbles.
- Reset mid-operation: asserting rst clears all outputs immediately, and any in-flight sample is discarded. The first data_valid after deassertion is processed normally.
- No internal FSM. Purely a registered function of the sampled inputs.
- X-handling: undefined data_in bits with data_valid=0 have no effect.

Optional Feature:
- Macro PARITY_STICKY_EN.
- Defined: parity_type=11 selects mark parity, with parity_out=1 and parity_en=1 regardless of data.
- Not defined: 11 behaves exactly as 00 (parity_out=0, parity_en=0).
- All other encodings are unaffected by the macro.

Decomposition:
- Package parity_pkg holds:
  - 2-bit parity-mode constants PAR_NONE=00, PAR_ODD=01, PAR_EVEN=10, PAR_MARK=11.
  - The default DATA_WIDTH constant.
- The UART TX framer shares the same package.
- One combinational sub-module, parity_xor_tree, with a DATA_WIDTH parameter. It takes the data bits and returns the 1-bit ones-parity. parity_gen adds the mode decode and output registers.

Test Plan:
- Reset: rst=1, data_in=8'h01, parity_type=10, data_valid=1 -> parity_out=0, parity_en=0, out_valid=0 throughout reset.
- Even parity, data_valid=1 on consecutive cycles with data_in 8'h01, 8'h03, 8'hFF -> parity_out 1, 0, 0 on successive cycles; parity_en=1; out_valid pulses each cycle.
- Odd parity, data_valid=1 on consecutive cycles with data_in 8'h00, 8'h01, 8'h03, 8'hFF -> parity_out 1, 0, 1, 1 on successive cycles; parity_en=1.
- Hold and latency: odd mode, data_in=8'h00, one data_valid pulse, then data_valid=0 while data_in changes to 8'h01 -> parity_out=1 one cycle after the pulse and stays 1; out_valid high for exactly one cycle.
- None/11 mode:
  - parity_type=00 with data_in=8'hA5 -> parity_out=0, parity_en=0.
  - parity_type=11 without the macro -> same result.
  - parity_type=11 with PARITY_STICKY_EN -> parity_out=1, parity_en=1.
- Async reset mid-stream: even mode, data_in=8'h01 producing parity_out=1, then assert rst between clock edges -> parity_out and parity_en go to 0 before the next edge; after release, data_in=8'h07 with data_valid=1 -> parity_out=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared UART parity definitions: parity-mode encodings and the default data width.
// Used by parity_gen and the TX framer.
package parity_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam int PAR_DATA_WIDTH = 8;

endpackage

// File: rtl/parity_xor_tree.sv
// Combinational ones-parity of a data word: 1 when the word holds an odd number of ones.
module parity_xor_tree #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ones
);

    assign ones = ^data;

endmodule

// File: rtl/parity_gen.sv
// Registered UART TX parity-bit generator with one-cycle latency.
// Optional macro PARITY_STICKY_EN: parity_type 11 selects mark parity instead of none.
module parity_gen
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = PAR_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    input  logic                  data_valid,
    output logic                  parity_out,
    output logic                  parity_en,
    output logic                  out_valid
);

    logic ones_p0;
    logic par_p1;
    logic en_p1;
    logic vld_p1;

    // Returns {parity_en, parity_bit} for a mode and the word's ones-parity.
    function automatic logic [1:0] decode_mode(input logic [1:0] mode, input logic ones);
        logic [1:0] res;
        res = 2'b00;
        case (mode)
            PAR_ODD:  res = {1'b1, ~ones};
            PAR_EVEN: res = {1'b1, ones};
`ifdef PARITY_STICKY_EN
            PAR_MARK: res = 2'b11;
`endif
            default:  res = 2'b00;
        endcase
        return res;
    endfunction

    parity_xor_tree #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xor_tree (
        .data (data_in),
        .ones (ones_p0)
    );

    // Stage p0 -> p1: sample on data_valid, otherwise hold the last result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_p1 <= 1'b0;
            en_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= data_valid;
            if (data_valid) begin
                {en_p1, par_p1} <= decode_mode(parity_type, ones_p0);
            end
        end
    end

    assign parity_out = par_p1;
    assign parity_en  = en_p1;
    assign out_valid  = vld_p1;

endmodule

// File: tb/tb_parity_gen.sv
// Self-checking bench for parity_gen: directed cases plus randomized traffic against a
// $countones-based reference model, including asynchronous resets between clock edges.
module tb_parity_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic [1:0]   parity_type;
    logic         data_valid;
    logic         parity_out;
    logic         parity_en;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parity_gen #(
        .DATA_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .parity_type (parity_type),
        .data_valid  (data_valid),
        .parity_out  (parity_out),
        .parity_en   (parity_en),
        .out_valid   (out_valid)
    );

    // Reference: returns {enable, parity bit} from the count of ones in the word
    function automatic logic [1:0] model(input logic [1:0] t, input logic [W-1:0] d);
        int n;
        n = $countones(d);
        if (t == 2'b10) return {1'b1, (n % 2) == 1};
        if (t == 2'b01) return {1'b1, (n % 2) == 0};
`ifdef PARITY_STICKY_EN
        if (t == 2'b11) return 2'b11;
`endif
        return 2'b00;
    endfunction

    logic [1:0] m_out;
    logic       m_vld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out <= 2'b00;
            m_vld <= 1'b0;
        end else begin
            m_vld <= data_valid;
            if (data_valid) m_out <= model(parity_type, data_in);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("model_out_valid",  out_valid,  m_vld);
            check("model_parity_out", parity_out, m_out[0]);
            check("model_parity_en",  parity_en,  m_out[1]);
        end
    end

    task automatic step(input logic v, input logic [1:0] t, input logic [W-1:0] d);
        data_valid  = v;
        parity_type = t;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input logic p, input logic e, input logic v);
        check({name, "_par"}, parity_out, p);
        check({name, "_en"},  parity_en,  e);
        check({name, "_vld"}, out_valid,  v);
    endtask

    logic sticky;

    initial begin
`ifdef PARITY_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        rst         = 1'b0;
        data_valid  = 1'b0;
        parity_type = 2'b00;
        data_in     = '0;
        #1 rst = 1'b1;
        data_in     = 8'h01;
        parity_type = 2'b10;
        data_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect3("reset", 1'b0, 1'b0, 1'b0);
        data_valid = 1'b0;
        rst = 1'b0;

        // Even parity, back-to-back
        step(1'b1, 2'b10, 8'h01); expect3("even_01", 1'b1, 1'b1, 1'b1);
        step(1'b1, 2'b10, 8'h03); expect3("even_03", 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'b10, 8'hFF); expect3("even_ff", 1'b0, 1'b1, 1'b1);

        // Odd parity, back-to-back
        step(1'b1, 2'b01, 8'h00); expect3("odd_00", 1'b1, 1'b1, 1'b1);
        step(1'b1, 2'b01, 8'h01); expect3("odd_01", 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'b01, 8'h03); expect3("odd_03", 1'b1, 1'b1, 1'b1);
        step(1'b1, 2'b01, 8'hFF); expect3("odd_ff", 1'b1, 1'b1, 1'b1);

        // Hold: one pulse, then data changes with data_valid low
        step(1'b1, 2'b01, 8'h00); expect3("hold_pulse", 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'b01, 8'h01); expect3("hold_1",     1'b1, 1'b1, 1'b0);
        step(1'b0, 2'b01, 8'h01); expect3("hold_2",     1'b1, 1'b1, 1'b0);

        // None and 11 modes
        step(1'b1, 2'b00, 8'hA5); expect3("none_a5", 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b11, 8'hA5); expect3("mode11_a5", sticky, sticky, 1'b1);
        step(1'b1, 2'b11, 8'h01); expect3("mode11_01", sticky, sticky, 1'b1);

        // Asynchronous reset between clock edges
        step(1'b1, 2'b10, 8'h01); expect3("pre_rst", 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1 expect3("async_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 expect3("rst_held", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        data_valid = 1'b0;
        step(1'b1, 2'b10, 8'h07); expect3("post_rst_07", 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'b10, 8'h00); expect3("post_rst_hold", 1'b1, 1'b1, 1'b0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom));
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b1;
                #1 expect3("rand_rst", 1'b0, 1'b0, 1'b0);
                #2 rst = 1'b0;
            end
        end

        step(1'b0, 2'b00, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
